ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Two-requester round-robin arbiter and access sequencer in front of the 16-bit single-port asynchronous RAM.
- Converts clocked valid/grant requests into a safe strobe sequence on the RAM pins: address and data are set up before the write strobe, and address is held after it.
- Registers read data and returns a one-cycle completion pulse to the requester that owns the access.
- Sits between the bus clients and the RAM instance; it is the only driver of the RAM addr/din/we/cs pins.

Parameters:
- ADDR_WIDTH, 8, RAM address width
- DATA_WIDTH, 16, RAM data width

Ports:
- clk  input  1  single system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req0  input  1  requester 0 access request, level
- we0  input  1  requester 0 op: 1=write, 0=read
- addr0  input  ADDR_WIDTH  requester 0 address
- wdata0  input  DATA_WIDTH  requester 0 write data
- gnt0  output  1  requester 0 accept pulse
- done0  output  1  requester 0 completion pulse
- rdata0  output  DATA_WIDTH  requester 0 read data
- req1, we1, addr1, wdata1, gnt1, done1, rdata1  same as above, for requester 1
- ram_addr  output  ADDR_WIDTH  to RAM addr
- ram_din  output  DATA_WIDTH  to RAM din
- ram_we  output  1  to RAM we
- ram_cs  output  1  to RAM cs
- ram_dout  input  DATA_WIDTH  from RAM dout
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, all outputs 0, rr pointer favours requester 0. ram_cs and ram_we fall without waiting for a clock edge.
- FSM states: IDLE -> SETUP -> STROBE -> HOLD -> IDLE. The sequence is fixed at 4 cycles per access; 1 access per 4 clocks maximum.
- IDLE:
  - If any req is high, grant exactly one requester. gntN is combinational, high only in IDLE.
  - On that edge, latch owner, we, addr and wdata, then move to SETUP.
  - With no req, remain in IDLE with ram_cs=0 and ram_we=0.
- Arbitration:
  - Only one req high: that requester wins.
  - Both high: the requester selected by the rr pointer wins.
  - After each grant, the pointer moves to the other requester. With both held high continuously, the grant sequence is 0,1,0,1...
- SETUP: ram_cs=1, ram_we=0, ram_addr and ram_din driven from the latched values.
- STROBE:
  - ram_cs=1.
  - ram_we=1 for a write, 0 for a read.
  - For a read, ram_dout is captured into the owner's rdata register at the end of the cycle.
- HOLD:
  - ram_cs=1, ram_we=0, address and data unchanged.
  - doneN=1 for the owner only, for exactly one cycle.
  - Applies to both reads and writes.
- Output registers:
  - All ram_* outputs come from flops; there is no combinational path from requester inputs to the RAM pins.
  - ram_addr and ram_din are stable from SETUP through HOLD. They keep their last value in IDLE, where only cs/we drop.
- rdataN holds its last read value until the next read completes for that requester. Writes leave it unchanged.
- Requester rules:
  - The requester keeps req, we, addr and wdata stable until it sees gnt.
  - After gnt it may change them freely.
  - A req still high after done is treated as a new request.
- Latency: gnt at cycle 0, done at cycle 3. For reads, rdata is valid from the done cycle onward.
- A req that rises while busy=1 waits, with no gnt, until the FSM returns to IDLE.
- Reset mid-access: the access is abandoned, with no done pulse. A write interrupted during STROBE may leave the RAM location undefined.

Test Plan:
- Single write then read on requester 0:
  - Stimulus: write 0x05=0xAAAA, then read 0x05.
  - Response: gnt0 at cycle 0; ram_we high only in the STROBE cycle; done0 at cycle 3; rdata0=0xAAAA.
- Round-robin under contention:
  - Stimulus: req0 and req1 both held high from reset. R0 writes 0x06=0x5555; R1 writes 0x07=0xF00D.
  - Response: grant order 0,1,0,1; each gnt is 4 cycles apart; no cycle where gnt0 and gnt1 are both high.
- Per-requester read data isolation:
  - Stimulus: R1 reads 0x07, then R0 reads 0x06.
  - Response: rdata1=0xF00D and rdata0=0x5555; done1 and done0 pulse only for their own accesses; rdata1 does not change during R0's read.
- Write timing on the RAM pins:
  - Check: ram_addr and ram_din are stable one full cycle before ram_we rises and one full cycle after it falls; ram_cs is high for SETUP, STROBE and HOLD; ram_cs and ram_we are 0 in IDLE.
- Request while busy:
  - Stimulus: req1 asserted in the SETUP cycle of an R0 access.
  - Response: gnt1 is held off until the cycle after done0, i.e. the next IDLE.
- Reset mid-operation:
  - Stimulus: rst_n pulled low in the STROBE cycle of a write.
  - Response: ram_we and ram_cs drop immediately with no clock edge; busy=0; no done pulse. After reset is released, a fresh request is granted to requester 0.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Two-requester round-robin arbiter and access sequencer for a single-port
// asynchronous RAM. Each access runs a fixed four-cycle sequence
// IDLE -> SETUP -> STROBE -> HOLD so that the RAM sees:
//   - address/data set up before the write strobe,
//   - a one-cycle write strobe,
//   - address/data held after the strobe.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   reqN, weN, addrN, wdataN   requester N request level, op (1=write), address, write data
//   gntN                       requester N accept pulse (combinational, IDLE only)
//   doneN                      requester N completion pulse (HOLD cycle of its access)
//   rdataN                     requester N registered read data
//   ram_addr, ram_din          registered RAM address / write data
//   ram_we, ram_cs             registered RAM write strobe / chip select
//   ram_dout                   RAM read data
//   busy                       high whenever an access is in progress
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  gnt0,
    output logic                  done0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic                  done1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_we,
    output logic                  ram_cs,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t                  state_reg, state_next;
    logic                    rr_ptr_reg;     // 1 = requester 1 wins a tie
    logic                    owner_reg;      // requester that owns the access
    logic                    op_we_reg;      // latched operation of the access
    logic [ADDR_WIDTH-1:0]   ram_addr_reg;
    logic [DATA_WIDTH-1:0]   ram_din_reg;
    logic                    ram_we_reg;
    logic                    ram_cs_reg;
    logic [1:0]              gnt_vec;
    logic                    win1;
    logic                    grant_any;

    // Requester 1 wins if it is the only one asking, or on a tie when the
    // pointer favours it.
    assign win1      = req1 && (!req0 || rr_ptr_reg);
    assign grant_any = |gnt_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        gnt_vec    = 2'b00;
        case (state_reg)
            IDLE: begin
                // Grants are suppressed while reset is held so every output
                // reads zero during reset.
                if (rst_n && (req0 || req1)) begin
                    gnt_vec    = win1 ? 2'b10 : 2'b01;
                    state_next = SETUP;
                end
            end
            SETUP:   state_next = STROBE;
            STROBE:  state_next = HOLD;
            HOLD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shared access datapath. All RAM pins come straight from these flops;
    // the asynchronous reset drops cs/we without waiting for an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg   <= 1'b0;
            owner_reg    <= 1'b0;
            op_we_reg    <= 1'b0;
            ram_addr_reg <= '0;
            ram_din_reg  <= '0;
            ram_we_reg   <= 1'b0;
            ram_cs_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        owner_reg    <= win1;
                        op_we_reg    <= win1 ? we1 : we0;
                        ram_addr_reg <= win1 ? addr1 : addr0;
                        ram_din_reg  <= win1 ? wdata1 : wdata0;
                        ram_cs_reg   <= 1'b1;
                        rr_ptr_reg   <= ~win1;
                    end
                end
                SETUP:   ram_we_reg <= op_we_reg;
                STROBE:  ram_we_reg <= 1'b0;
                HOLD:    ram_cs_reg <= 1'b0;  // addr/din keep their last value
                default: ;
            endcase
        end
    end

    // Per-requester completion pulse and read-data register.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            logic                  done_reg;
            logic [DATA_WIDTH-1:0] rdata_reg;
            logic                  owns;

            assign owns = (state_reg == STROBE) && (owner_reg == 1'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    done_reg  <= 1'b0;
                    rdata_reg <= '0;
                end else begin
                    // STROBE is always followed by HOLD, so this is high for
                    // exactly the HOLD cycle.
                    done_reg <= owns;
                    if (owns && !op_we_reg) begin
                        rdata_reg <= ram_dout;
                    end
                end
            end
        end
    endgenerate

    assign gnt0     = gnt_vec[0];
    assign gnt1     = gnt_vec[1];
    assign done0    = g_req[0].done_reg;
    assign done1    = g_req[1].done_reg;
    assign rdata0   = g_req[0].rdata_reg;
    assign rdata1   = g_req[1].rdata_reg;
    assign ram_addr = ram_addr_reg;
    assign ram_din  = ram_din_reg;
    assign ram_we   = ram_we_reg;
    assign ram_cs   = ram_cs_reg;
    assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed testbench for ram_port_arbiter with a behavioural asynchronous RAM.
module tb_ram_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, we0, gnt0, done0;
    logic [7:0]  addr0;
    logic [15:0] wdata0, rdata0;
    logic        req1, we1, gnt1, done1;
    logic [7:0]  addr1;
    logic [15:0] wdata1, rdata1;
    logic [7:0]  ram_addr;
    logic [15:0] ram_din, ram_dout;
    logic        ram_we, ram_cs, busy;

    int checks = 0;
    int errors = 0;

    ram_port_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .done0(done0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .done1(done1), .rdata1(rdata1),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .ram_cs(ram_cs), .ram_dout(ram_dout), .busy(busy)
    );

    // Behavioural RAM: combinational read, write while cs and we are high.
    logic [15:0] mem [256];
    always @(posedge clk) begin
        if (ram_cs && ram_we) mem[ram_addr] <= ram_din;
    end
    assign ram_dout = mem[ram_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        logic [8:0] obs;
        rst_n = 1'b0;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            obs = {gnt0, gnt1, busy, ram_cs, ram_we, done0, done1, |rdata0, |rdata1};
            checks++;
            if (obs !== 9'b0) begin
                errors++;
                $display("FAIL reset outputs cycle %0d: got %b expected %b", c, obs, 9'b0);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // R0 writes 0x05=0xAAAA then reads it back; also checks pin timing.
    task automatic test_write_read();
        logic [6:0]  obs, exp;
        logic [15:0] exp_din;
        for (int op = 0; op < 2; op++) begin
            exp_din = (op == 0) ? 16'hAAAA : 16'h0000;
            @(posedge clk); #1;
            req0 = 1; we0 = (op == 0); addr0 = 8'h05; wdata0 = exp_din;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                case (c)
                    0:       exp = 7'b1000000;
                    1:       exp = 7'b0011000;
                    2:       exp = {4'b0011, (op == 0), 2'b00};
                    3:       exp = 7'b0011010;
                    default: exp = 7'b0000000;
                endcase
                obs = {gnt0, gnt1, busy, ram_cs, ram_we, done0, done1};
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL wr_rd op%0d cycle %0d {gnt0,gnt1,busy,cs,we,done0,done1}: got %b expected %b", op, c, obs, exp);
                end
                if (c >= 1 && c <= 3) begin
                    checks++;
                    if (ram_addr !== 8'h05 || ram_din !== exp_din) begin
                        errors++;
                        $display("FAIL wr_rd pins op%0d cycle %0d: got addr %h din %h expected addr 05 din %h", op, c, ram_addr, ram_din, exp_din);
                    end
                end
                if (c == 3 && op == 1) begin
                    checks++;
                    if (rdata0 !== 16'hAAAA) begin
                        errors++;
                        $display("FAIL wr_rd rdata0: got %h expected aaaa", rdata0);
                    end
                end
                if (c == 0) begin
                    @(posedge clk); #1;
                    req0 = 0;
                end
            end
        end
    endtask

    // Both requesters held high from reset: grants 0,1,0,1 four cycles apart.
    task automatic test_round_robin();
        logic [3:0] obs, exp;
        logic       odd;
        @(posedge clk); #1;
        rst_n = 1'b0;
        req0 = 1; we0 = 1; addr0 = 8'h06; wdata0 = 16'h5555;
        req1 = 1; we1 = 1; addr1 = 8'h07; wdata1 = 16'hF00D;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            odd = ((k / 4) % 2) == 1;
            exp = {(k % 4 == 0) && !odd, (k % 4 == 0) && odd,
                   (k % 4 == 3) && !odd, (k % 4 == 3) && odd};
            obs = {gnt0, gnt1, done0, done1};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL rr cycle %0d {gnt0,gnt1,done0,done1}: got %b expected %b", k, obs, exp);
            end
            if (k % 4 == 1) begin
                checks++;
                if (ram_addr !== (odd ? 8'h07 : 8'h06) || ram_din !== (odd ? 16'hF00D : 16'h5555)) begin
                    errors++;
                    $display("FAIL rr pins cycle %0d: got addr %h din %h expected addr %h din %h", k, ram_addr, ram_din, odd ? 8'h07 : 8'h06, odd ? 16'hF00D : 16'h5555);
                end
            end
        end
        req0 = 0;
        req1 = 0;
    endtask

    // R1 reads 0x07, then R0 reads 0x06; each rdata only moves on its own read.
    task automatic test_isolation();
        logic [6:0] obs, exp;
        logic       r1;
        for (int op = 0; op < 2; op++) begin
            r1 = (op == 0);
            @(posedge clk); #1;
            if (r1) begin req1 = 1; we1 = 0; addr1 = 8'h07; end
            else    begin req0 = 1; we0 = 0; addr0 = 8'h06; end
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                case (c)
                    0:       exp = r1 ? 7'b0100000 : 7'b1000000;
                    1, 2:    exp = 7'b0011000;
                    3:       exp = r1 ? 7'b0011001 : 7'b0011010;
                    default: exp = 7'b0000000;
                endcase
                obs = {gnt0, gnt1, busy, ram_cs, ram_we, done0, done1};
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL iso op%0d cycle %0d {gnt0,gnt1,busy,cs,we,done0,done1}: got %b expected %b", op, c, obs, exp);
                end
                if (c == 3 && r1) begin
                    checks++;
                    if (rdata1 !== 16'hF00D || rdata0 !== 16'h0000) begin
                        errors++;
                        $display("FAIL iso r1 read: got rdata1 %h rdata0 %h expected f00d 0000", rdata1, rdata0);
                    end
                end
                if (!r1) begin
                    checks++;
                    if (rdata1 !== 16'hF00D) begin
                        errors++;
                        $display("FAIL iso rdata1 held cycle %0d: got %h expected f00d", c, rdata1);
                    end
                    if (c == 3) begin
                        checks++;
                        if (rdata0 !== 16'h5555) begin
                            errors++;
                            $display("FAIL iso r0 read: got rdata0 %h expected 5555", rdata0);
                        end
                    end
                end
                if (c == 0) begin
                    @(posedge clk); #1;
                    req0 = 0;
                    req1 = 0;
                end
            end
        end
    endtask

    // req1 raised in SETUP of an R0 write waits until the next IDLE.
    task automatic test_busy_req();
        logic [6:0] obs, exp;
        @(posedge clk); #1;
        req0 = 1; we0 = 1; addr0 = 8'h08; wdata0 = 16'h1234;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            case (c)
                0:       exp = 7'b1000000;
                1:       exp = 7'b0011000;
                2:       exp = 7'b0011100;
                3:       exp = 7'b0011010;
                4:       exp = 7'b0100000;
                5, 6:    exp = 7'b0011000;
                7:       exp = 7'b0011001;
                default: exp = 7'b0000000;
            endcase
            obs = {gnt0, gnt1, busy, ram_cs, ram_we, done0, done1};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL busy cycle %0d {gnt0,gnt1,busy,cs,we,done0,done1}: got %b expected %b", c, obs, exp);
            end
            if (c == 7) begin
                checks++;
                if (rdata1 !== 16'h1234) begin
                    errors++;
                    $display("FAIL busy rdata1: got %h expected 1234", rdata1);
                end
            end
            if (c == 0) begin
                @(posedge clk); #1;
                req0 = 0;
                req1 = 1; we1 = 0; addr1 = 8'h08;
            end else if (c == 4) begin
                @(posedge clk); #1;
                req1 = 0;
            end
        end
    endtask

    // Reset in the STROBE cycle of a write; afterwards R0 wins a tie.
    task automatic test_reset_mid();
        logic [4:0] obs5;
        logic [3:0] obs, exp;
        @(posedge clk); #1;
        req0 = 1; we0 = 1; addr0 = 8'h09; wdata0 = 16'hBEEF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) begin
                checks++;
                if (gnt0 !== 1'b1) begin
                    errors++;
                    $display("FAIL rstmid gnt0: got %b expected 1", gnt0);
                end
                @(posedge clk); #1;
                req0 = 0;
            end
        end
        checks++;
        if ({ram_cs, ram_we} !== 2'b11) begin
            errors++;
            $display("FAIL rstmid strobe {cs,we}: got %b expected 11", {ram_cs, ram_we});
        end
        #1;
        rst_n = 1'b0;
        req0 = 1; we0 = 0; addr0 = 8'h05;
        req1 = 1; we1 = 0; addr1 = 8'h07;
        #1;
        obs5 = {busy, ram_cs, ram_we, done0, done1};
        checks++;
        if (obs5 !== 5'b0) begin
            errors++;
            $display("FAIL rstmid async {busy,cs,we,done0,done1}: got %b expected 00000", obs5);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            obs5 = {busy, ram_cs, ram_we, done0, done1};
            checks++;
            if (obs5 !== 5'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
                errors++;
                $display("FAIL rstmid held cycle %0d: got flags %b gnt %b%b expected all 0", c, obs5, gnt0, gnt1);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            case (c)
                0:       exp = 4'b1000;
                3:       exp = 4'b0010;
                4:       exp = 4'b0100;
                7:       exp = 4'b0001;
                default: exp = 4'b0000;
            endcase
            obs = {gnt0, gnt1, done0, done1};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL rstmid after cycle %0d {gnt0,gnt1,done0,done1}: got %b expected %b", c, obs, exp);
            end
            if (c == 3) begin
                checks++;
                if (rdata0 !== 16'hAAAA) begin
                    errors++;
                    $display("FAIL rstmid rdata0: got %h expected aaaa", rdata0);
                end
            end
            if (c == 7) begin
                checks++;
                if (rdata1 !== 16'hF00D) begin
                    errors++;
                    $display("FAIL rstmid rdata1: got %h expected f00d", rdata1);
                end
            end
            if (c == 0) begin
                @(posedge clk); #1;
                req0 = 0;
            end else if (c == 4) begin
                @(posedge clk); #1;
                req1 = 0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_isolation();
        test_busy_req();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
